// File: rtl/usb_defs_pkg.sv
// Shared USB packet definitions for the packet router: PID codes, router states
// and PID class helpers.
package usb_defs_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_DATA,
    ST_RX_DATA,
    ST_RX_RESP,
    ST_TX_DATA,
    ST_WAIT_ACK
  } state_t;

  function automatic logic is_token(input logic [3:0] pid);
    return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SETUP);
  endfunction

  function automatic logic is_data(input logic [3:0] pid);
    return (pid == PID_DATA0) || (pid == PID_DATA1);
  endfunction

endpackage

// File: rtl/usb_toggle_bank.sv
// Per-endpoint DATA0/DATA1 toggle bits for the receive and transmit directions.
// Clear wins over set, set wins over flip.
module usb_toggle_bank #(
  parameter int unsigned NUM_EP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_EP-1:0] clr,
  input  logic [NUM_EP-1:0] rx_set,
  input  logic [NUM_EP-1:0] tx_set,
  input  logic [NUM_EP-1:0] rx_flip,
  input  logic [NUM_EP-1:0] tx_flip,
  output logic [NUM_EP-1:0] rx_tog,
  output logic [NUM_EP-1:0] tx_tog
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_tog <= '0;
      tx_tog <= '0;
    end else begin
      rx_tog <= ((rx_tog ^ rx_flip) | rx_set) & ~clr;
      tx_tog <= ((tx_tog ^ tx_flip) | tx_set) & ~clr;
    end
  end

endmodule

// File: rtl/usb_pkt_router.sv
// Routes host token/data/handshake packets to NUM_EP endpoint engines with
// address filtering, data toggle tracking and ACK/NAK/STALL generation.
module usb_pkt_router
  import usb_defs_pkg::*;
#(
  parameter int unsigned NUM_EP  = 4,
  parameter int unsigned MAX_PKT = 64,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              dev_addr,
  input  logic [NUM_EP-1:0]       ep_stall,
  input  logic                    host_pkt_valid,
  input  logic [3:0]              host_pid,
  input  logic [6:0]              host_addr,
  input  logic [3:0]              host_ep,
  input  logic [7:0]              host_data,
  input  logic                    host_data_valid,
  input  logic [LEN_W-1:0]        host_data_len,
  input  logic                    host_crc_err,
  output logic [NUM_EP-1:0]       ep_rx_sel,
  output logic [3:0]              ep_rx_pid,
  output logic [7:0]              ep_rx_data,
  output logic                    ep_rx_data_valid,
  input  logic [NUM_EP-1:0]       ep_rx_ready,
  output logic                    ep_rx_commit,
  output logic                    ep_rx_abort,
  input  logic [NUM_EP-1:0]       ep_tx_req,
  input  logic [NUM_EP*LEN_W-1:0] ep_tx_len,
  input  logic [NUM_EP*8-1:0]     ep_tx_data,
  output logic [NUM_EP-1:0]       ep_tx_rd,
  output logic [NUM_EP-1:0]       ep_tx_done,
  output logic [NUM_EP-1:0]       ep_tx_fail,
  output logic                    host_tx_valid,
  output logic [3:0]              host_tx_pid,
  output logic [7:0]              host_tx_data,
  output logic [LEN_W-1:0]        host_tx_len,
  output logic                    host_tx_last,
  output logic                    busy
);

  localparam int unsigned TM_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [NUM_EP-1:0] cur_sel;
  logic [3:0]        rx_data_pid;
  logic [LEN_W-1:0]  rx_len;
  logic [LEN_W-1:0]  tx_len;
  logic [LEN_W-1:0]  cnt;
  logic [TM_W-1:0]   timer;
  logic              crc_q;

  logic [NUM_EP-1:0] rx_tog, tx_tog;
  logic [NUM_EP-1:0] tog_clr_c, rx_flip_c, tx_flip_c;
  logic [NUM_EP-1:0] tok_sel_c, mux_sel_c;
  logic              tok_ok_c, timeout_c, rx_good_c;
  logic              sel_stall_c, sel_ready_c, sel_tx_req_c, sel_rx_tog_c, sel_tx_tog_c;
  logic [LEN_W-1:0]  sel_tx_len_c;
  logic [7:0]        sel_tx_data_c;

  usb_toggle_bank #(.NUM_EP(NUM_EP)) u_toggle_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tog_clr_c),
    .rx_set  ('0),
    .tx_set  ('0),
    .rx_flip (rx_flip_c),
    .tx_flip (tx_flip_c),
    .rx_tog  (rx_tog),
    .tx_tog  (tx_tog)
  );

  // Endpoint selection: the incoming token in IDLE, otherwise the latched endpoint.
  always_comb begin
    tok_sel_c     = NUM_EP'(1) << host_ep;
    tok_ok_c      = host_pkt_valid && is_token(host_pid) && (host_addr == dev_addr) &&
                    (5'(host_ep) < 5'(NUM_EP));
    mux_sel_c     = (state == ST_IDLE) ? tok_sel_c : cur_sel;
    sel_stall_c   = |(ep_stall & mux_sel_c);
    sel_ready_c   = |(ep_rx_ready & mux_sel_c);
    sel_tx_req_c  = |(ep_tx_req & mux_sel_c);
    sel_rx_tog_c  = |(rx_tog & mux_sel_c);
    sel_tx_tog_c  = |(tx_tog & mux_sel_c);
    sel_tx_len_c  = '0;
    sel_tx_data_c = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (mux_sel_c[i]) begin
        sel_tx_len_c  = sel_tx_len_c | ep_tx_len[i*LEN_W +: LEN_W];
        sel_tx_data_c = sel_tx_data_c | ep_tx_data[i*8 +: 8];
      end
    end
    timeout_c = (timer == TM_W'(TIMEOUT - 1));
    rx_good_c = !crc_q && !(sel_stall_c && (ep_rx_pid != PID_SETUP)) && sel_ready_c &&
                ((rx_data_pid == PID_DATA1) == sel_rx_tog_c);
  end

  // Toggle updates land on the same edge as the matching commit/done pulse.
  always_comb begin
    tog_clr_c = '0;
    rx_flip_c = '0;
    tx_flip_c = '0;
    if (state == ST_IDLE && tok_ok_c && host_pid == PID_SETUP) tog_clr_c = tok_sel_c;
    if (state == ST_RX_RESP && rx_good_c) rx_flip_c = cur_sel;
    if (state == ST_WAIT_ACK && host_pkt_valid && host_pid == PID_ACK) tx_flip_c = cur_sel;
  end

  // FWFT byte passes straight through so the pop and the presented byte share a cycle.
  assign host_tx_data = (|ep_tx_rd) ? sel_tx_data_c : 8'h00;
  assign busy         = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      cur_sel          <= '0;
      rx_data_pid      <= '0;
      rx_len           <= '0;
      tx_len           <= '0;
      cnt              <= '0;
      timer            <= '0;
      crc_q            <= 1'b0;
      ep_rx_sel        <= '0;
      ep_rx_pid        <= '0;
      ep_rx_data       <= '0;
      ep_rx_data_valid <= 1'b0;
      ep_rx_commit     <= 1'b0;
      ep_rx_abort      <= 1'b0;
      ep_tx_rd         <= '0;
      ep_tx_done       <= '0;
      ep_tx_fail       <= '0;
      host_tx_valid    <= 1'b0;
      host_tx_pid      <= '0;
      host_tx_len      <= '0;
      host_tx_last     <= 1'b0;
    end else begin
      ep_rx_data_valid <= 1'b0;
      ep_rx_commit     <= 1'b0;
      ep_rx_abort      <= 1'b0;
      ep_tx_rd         <= '0;
      ep_tx_done       <= '0;
      ep_tx_fail       <= '0;
      host_tx_valid    <= 1'b0;
      host_tx_pid      <= '0;
      host_tx_len      <= '0;
      host_tx_last     <= 1'b0;
      if (timer != '1) timer <= timer + TM_W'(1);

      case (state)
        ST_IDLE: begin
          ep_rx_sel <= '0;
          ep_rx_pid <= '0;
          timer     <= '0;
          cnt       <= '0;
          if (tok_ok_c) begin
            cur_sel <= tok_sel_c;
            if (host_pid == PID_IN) begin
              if (sel_stall_c) begin
                host_tx_valid <= 1'b1;
                host_tx_pid   <= PID_STALL;
                host_tx_last  <= 1'b1;
              end else if (!sel_tx_req_c) begin
                host_tx_valid <= 1'b1;
                host_tx_pid   <= PID_NAK;
                host_tx_last  <= 1'b1;
              end else begin
                tx_len <= sel_tx_len_c;
                state  <= ST_TX_DATA;
              end
            end else begin
              ep_rx_sel <= tok_sel_c;
              ep_rx_pid <= host_pid;
              state     <= ST_WAIT_DATA;
            end
          end
        end

        ST_WAIT_DATA: begin
          if (host_pkt_valid) begin
            if (is_data(host_pid)) begin
              rx_data_pid <= host_pid;
              rx_len      <= host_data_len;
              cnt         <= '0;
              timer       <= '0;
              if (host_data_len == '0) begin
                crc_q <= host_crc_err;
                state <= ST_RX_RESP;
              end else begin
                state <= ST_RX_DATA;
              end
            end else begin
              ep_rx_abort <= 1'b1;
              state       <= ST_IDLE;
            end
          end else if (timeout_c) begin
            ep_rx_abort <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        // Oversized packets are dropped silently; a stalled byte stream also times out.
        ST_RX_DATA: begin
          if (rx_len > LEN_W'(MAX_PKT)) begin
            ep_rx_abort <= 1'b1;
            state       <= ST_IDLE;
          end else if (host_data_valid) begin
            ep_rx_data_valid <= 1'b1;
            ep_rx_data       <= host_data;
            cnt              <= cnt + LEN_W'(1);
            timer            <= '0;
            if (cnt + LEN_W'(1) == rx_len) begin
              crc_q <= host_crc_err;
              state <= ST_RX_RESP;
            end
          end else if (timeout_c) begin
            ep_rx_abort <= 1'b1;
            state       <= ST_IDLE;
          end
        end

        ST_RX_RESP: begin
          state <= ST_IDLE;
          if (crc_q) begin
            ep_rx_abort <= 1'b1;
          end else if (sel_stall_c && ep_rx_pid != PID_SETUP) begin
            host_tx_valid <= 1'b1;
            host_tx_pid   <= PID_STALL;
            host_tx_last  <= 1'b1;
            ep_rx_abort   <= 1'b1;
          end else if (!sel_ready_c) begin
            host_tx_valid <= 1'b1;
            host_tx_pid   <= PID_NAK;
            host_tx_last  <= 1'b1;
            ep_rx_abort   <= 1'b1;
          end else begin
            host_tx_valid <= 1'b1;
            host_tx_pid   <= PID_ACK;
            host_tx_last  <= 1'b1;
            ep_rx_commit  <= rx_good_c;
            ep_rx_abort   <= !rx_good_c;
          end
        end

        ST_TX_DATA: begin
          host_tx_valid <= 1'b1;
          host_tx_pid   <= sel_tx_tog_c ? PID_DATA1 : PID_DATA0;
          host_tx_len   <= tx_len;
          timer         <= '0;
          if (tx_len == '0) begin
            host_tx_last <= 1'b1;
            state        <= ST_WAIT_ACK;
          end else begin
            ep_tx_rd <= cur_sel;
            cnt      <= cnt + LEN_W'(1);
            if (cnt == tx_len - LEN_W'(1)) begin
              host_tx_last <= 1'b1;
              state        <= ST_WAIT_ACK;
            end
          end
        end

        ST_WAIT_ACK: begin
          if (host_pkt_valid) begin
            state <= ST_IDLE;
            if (host_pid == PID_ACK) ep_tx_done <= cur_sel;
            else                     ep_tx_fail <= cur_sel;
          end else if (timeout_c) begin
            ep_tx_fail <= cur_sel;
            state      <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_pkt_router.sv
// Directed self-checking bench for usb_pkt_router with a FWFT endpoint model
// and a negedge monitor that logs every host beat and endpoint pulse.
module tb_usb_pkt_router;
  import usb_defs_pkg::*;

  localparam int unsigned NUM_EP = 4;
  localparam int unsigned LEN_W  = 16;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [6:0]              dev_addr;
  logic [NUM_EP-1:0]       ep_stall;
  logic                    host_pkt_valid;
  logic [3:0]              host_pid;
  logic [6:0]              host_addr;
  logic [3:0]              host_ep;
  logic [7:0]              host_data;
  logic                    host_data_valid;
  logic [LEN_W-1:0]        host_data_len;
  logic                    host_crc_err;
  logic [NUM_EP-1:0]       ep_rx_sel;
  logic [3:0]              ep_rx_pid;
  logic [7:0]              ep_rx_data;
  logic                    ep_rx_data_valid;
  logic [NUM_EP-1:0]       ep_rx_ready;
  logic                    ep_rx_commit;
  logic                    ep_rx_abort;
  logic [NUM_EP-1:0]       ep_tx_req;
  logic [NUM_EP*LEN_W-1:0] ep_tx_len;
  logic [NUM_EP*8-1:0]     ep_tx_data;
  logic [NUM_EP-1:0]       ep_tx_rd;
  logic [NUM_EP-1:0]       ep_tx_done;
  logic [NUM_EP-1:0]       ep_tx_fail;
  logic                    host_tx_valid;
  logic [3:0]              host_tx_pid;
  logic [7:0]              host_tx_data;
  logic [LEN_W-1:0]        host_tx_len;
  logic                    host_tx_last;
  logic                    busy;

  usb_pkt_router #(.NUM_EP(NUM_EP), .MAX_PKT(64), .LEN_W(LEN_W), .TIMEOUT(32)) dut (
    .clk(clk), .rst_n(rst_n), .dev_addr(dev_addr), .ep_stall(ep_stall),
    .host_pkt_valid(host_pkt_valid), .host_pid(host_pid), .host_addr(host_addr),
    .host_ep(host_ep), .host_data(host_data), .host_data_valid(host_data_valid),
    .host_data_len(host_data_len), .host_crc_err(host_crc_err),
    .ep_rx_sel(ep_rx_sel), .ep_rx_pid(ep_rx_pid), .ep_rx_data(ep_rx_data),
    .ep_rx_data_valid(ep_rx_data_valid), .ep_rx_ready(ep_rx_ready),
    .ep_rx_commit(ep_rx_commit), .ep_rx_abort(ep_rx_abort),
    .ep_tx_req(ep_tx_req), .ep_tx_len(ep_tx_len), .ep_tx_data(ep_tx_data),
    .ep_tx_rd(ep_tx_rd), .ep_tx_done(ep_tx_done), .ep_tx_fail(ep_tx_fail),
    .host_tx_valid(host_tx_valid), .host_tx_pid(host_tx_pid), .host_tx_data(host_tx_data),
    .host_tx_len(host_tx_len), .host_tx_last(host_tx_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]        pid;
    logic [7:0]        data;
    logic [LEN_W-1:0]  len;
    logic              last;
    logic [NUM_EP-1:0] rd;
    int                cyc;
  } beat_t;

  beat_t             beats[$];
  int                cyc = 0;
  int                n_rxv = 0, rx_sum = 0, n_commit = 0, n_abort = 0, n_done = 0, n_fail = 0;
  int                fail_cyc = 0;
  logic [NUM_EP-1:0] commit_sel = '0, done_sel = '0, fail_sel = '0;
  logic [3:0]        commit_pid = '0;
  logic [7:0]        ptr [NUM_EP];
  int                tests = 0, fails = 0;

  // Endpoint model: byte k of EP i is 0xA0 + 16*i + k; pointer rewinds on done or fail.
  always @(posedge clk or negedge rst_n) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NUM_EP; i++) begin
      if (!rst_n || ep_tx_done[i] || ep_tx_fail[i]) ptr[i] <= 8'h00;
      else if (ep_tx_rd[i])                          ptr[i] <= ptr[i] + 8'h01;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_EP; i++) ep_tx_data[i*8 +: 8] = 8'(8'hA0 + 8'(i * 16) + ptr[i]);
  end

  always @(negedge clk) begin
    if (host_tx_valid) beats.push_back('{host_tx_pid, host_tx_data, host_tx_len, host_tx_last, ep_tx_rd, cyc});
    if (ep_rx_data_valid) begin n_rxv++; rx_sum += int'(ep_rx_data); end
    if (ep_rx_commit) begin n_commit++; commit_sel = ep_rx_sel; commit_pid = ep_rx_pid; end
    if (ep_rx_abort) n_abort++;
    if (|ep_tx_done) begin n_done++; done_sel = ep_tx_done; end
    if (|ep_tx_fail) begin n_fail++; fail_sel = ep_tx_fail; fail_cyc = cyc; end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hdr(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep);
    @(posedge clk); #1;
    host_pkt_valid = 1'b1; host_pid = pid; host_addr = addr; host_ep = ep;
    @(posedge clk); #1;
    host_pkt_valid = 1'b0;
  endtask

  task automatic data_pkt(input logic [3:0] pid, input int len, input int nbytes,
                          input logic [7:0] base, input logic crc);
    @(posedge clk); #1;
    host_pkt_valid = 1'b1; host_pid = pid; host_data_len = LEN_W'(len);
    host_crc_err = (nbytes == 0) ? crc : 1'b0;
    @(posedge clk); #1;
    host_pkt_valid = 1'b0; host_crc_err = 1'b0;
    for (int k = 0; k < nbytes; k++) begin
      host_data_valid = 1'b1; host_data = 8'(int'(base) + k);
      host_crc_err = (k == nbytes - 1) ? crc : 1'b0;
      @(posedge clk); #1;
    end
    host_data_valid = 1'b0; host_crc_err = 1'b0; host_data_len = '0;
  endtask

  task automatic test_reset();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (host_tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b expected 0", host_tx_valid); end
    tests++; if (ep_rx_sel !== 4'h0) begin fails++; $display("FAIL reset_rx_sel: got %h expected 0", ep_rx_sel); end
    tests++; if (ep_tx_rd !== 4'h0) begin fails++; $display("FAIL reset_tx_rd: got %h expected 0", ep_tx_rd); end
  endtask

  task automatic test_setup_rx();
    int b0, v0, s0, c0, a0;
    b0 = beats.size(); v0 = n_rxv; s0 = rx_sum; c0 = n_commit; a0 = n_abort;
    hdr(PID_SETUP, 7'd0, 4'd0);
    data_pkt(PID_DATA0, 8, 8, 8'h40, 1'b0);
    idle(5);
    tests++; if (n_rxv - v0 !== 8) begin fails++; $display("FAIL setup_beats: got %0d expected 8", n_rxv - v0); end
    tests++; if (rx_sum - s0 !== 540) begin fails++; $display("FAIL setup_sum: got %0d expected 540", rx_sum - s0); end
    tests++; if (n_commit - c0 !== 1 || n_abort - a0 !== 0) begin fails++; $display("FAIL setup_commit: got c%0d a%0d expected c1 a0", n_commit - c0, n_abort - a0); end
    tests++; if (commit_sel !== 4'b0001 || commit_pid !== PID_SETUP) begin fails++; $display("FAIL setup_sel_pid: got %h/%h expected 1/%h", commit_sel, commit_pid, PID_SETUP); end
    tests++; if (beats.size() - b0 !== 1 || beats[b0].pid !== PID_ACK || beats[b0].len !== 16'd0 || beats[b0].last !== 1'b1) begin
      fails++; $display("FAIL setup_ack: got n%0d pid %h len %0d last %b expected n1 ACK 0 1", beats.size() - b0, beats[b0].pid, beats[b0].len, beats[b0].last); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL setup_idle: got busy %b expected 0", busy); end
    // rx toggle of ep0 is now 1, so DATA1 must commit
    c0 = n_commit;
    hdr(PID_OUT, 7'd0, 4'd0);
    data_pkt(PID_DATA1, 4, 4, 8'h00, 1'b0);
    idle(5);
    tests++; if (n_commit - c0 !== 1) begin fails++; $display("FAIL setup_toggle: got %0d commits expected 1", n_commit - c0); end
  endtask

  task automatic test_dup_out();
    int b0, c0, a0;
    c0 = n_commit;
    hdr(PID_OUT, 7'd0, 4'd2); data_pkt(PID_DATA0, 2, 2, 8'h11, 1'b0); idle(5);
    tests++; if (n_commit - c0 !== 1) begin fails++; $display("FAIL dup_first: got %0d commits expected 1", n_commit - c0); end
    b0 = beats.size(); c0 = n_commit; a0 = n_abort;
    hdr(PID_OUT, 7'd0, 4'd2); data_pkt(PID_DATA0, 2, 2, 8'h11, 1'b0); idle(5);
    tests++; if (n_commit - c0 !== 0 || n_abort - a0 !== 1) begin fails++; $display("FAIL dup_second: got c%0d a%0d expected c0 a1", n_commit - c0, n_abort - a0); end
    tests++; if (beats[b0].pid !== PID_ACK) begin fails++; $display("FAIL dup_ack: got %h expected %h", beats[b0].pid, PID_ACK); end
    c0 = n_commit;
    hdr(PID_OUT, 7'd0, 4'd2); data_pkt(PID_DATA1, 1, 1, 8'h22, 1'b0); idle(5);
    tests++; if (n_commit - c0 !== 1) begin fails++; $display("FAIL dup_toggle_kept: got %0d commits expected 1", n_commit - c0); end
    // EP not ready -> NAK + abort
    ep_rx_ready = 4'b1011; b0 = beats.size(); a0 = n_abort;
    hdr(PID_OUT, 7'd0, 4'd2); data_pkt(PID_DATA0, 1, 1, 8'h33, 1'b0); idle(5);
    tests++; if (beats[b0].pid !== PID_NAK || n_abort - a0 !== 1) begin fails++; $display("FAIL out_nak: got %h a%0d expected %h a1", beats[b0].pid, n_abort - a0, PID_NAK); end
    ep_rx_ready = 4'b1111;
  endtask

  task automatic test_len_bounds();
    int b0, v0, c0, a0;
    b0 = beats.size(); v0 = n_rxv; a0 = n_abort;
    hdr(PID_OUT, 7'd0, 4'd0); data_pkt(PID_DATA0, 65, 0, 8'h00, 1'b0); idle(5);
    tests++; if (n_abort - a0 !== 1 || beats.size() !== b0 || n_rxv !== v0) begin
      fails++; $display("FAIL oversize: got a%0d beats%0d rx%0d expected a1 0 0", n_abort - a0, beats.size() - b0, n_rxv - v0); end
    v0 = n_rxv; c0 = n_commit;
    hdr(PID_OUT, 7'd0, 4'd0); data_pkt(PID_DATA0, 64, 64, 8'h00, 1'b0); idle(5);
    tests++; if (n_rxv - v0 !== 64 || n_commit - c0 !== 1) begin fails++; $display("FAIL maxpkt: got rx%0d c%0d expected 64 1", n_rxv - v0, n_commit - c0); end
    b0 = beats.size(); c0 = n_commit;
    hdr(PID_OUT, 7'd0, 4'd0); data_pkt(PID_DATA1, 0, 0, 8'h00, 1'b0); idle(5);
    tests++; if (n_commit - c0 !== 1 || beats[b0].pid !== PID_ACK) begin fails++; $display("FAIL out_zlp: got c%0d pid %h expected 1 %h", n_commit - c0, beats[b0].pid, PID_ACK); end
  endtask

  task automatic test_in_ack();
    int b0, d0;
    ep_tx_req = 4'b0010; ep_tx_len[LEN_W +: LEN_W] = 16'd3;
    b0 = beats.size(); d0 = n_done;
    hdr(PID_IN, 7'd0, 4'd1); idle(4);
    tests++; if (beats.size() - b0 !== 3) begin fails++; $display("FAIL in_beats: got %0d expected 3", beats.size() - b0); end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (beats[b0+k].pid !== PID_DATA0 || beats[b0+k].data !== 8'(8'hB0 + k) || beats[b0+k].rd !== 4'b0010 ||
          beats[b0+k].last !== (k == 2) || beats[b0+k].len !== 16'd3) begin
        fails++; $display("FAIL in_beat%0d: got pid %h data %h rd %h last %b len %0d expected %h %h 2 %b 3", k,
          beats[b0+k].pid, beats[b0+k].data, beats[b0+k].rd, beats[b0+k].last, beats[b0+k].len, PID_DATA0, 8'(8'hB0 + k), k == 2);
      end
    end
    hdr(PID_ACK, 7'd0, 4'd0); idle(3);
    tests++; if (n_done - d0 !== 1 || done_sel !== 4'b0010) begin fails++; $display("FAIL in_done: got %0d sel %h expected 1 2", n_done - d0, done_sel); end
    b0 = beats.size();
    hdr(PID_IN, 7'd0, 4'd1); idle(4);
    tests++; if (beats[b0].pid !== PID_DATA1 || beats[b0].data !== 8'hB0) begin fails++; $display("FAIL in_data1: got %h/%h expected %h/b0", beats[b0].pid, beats[b0].data, PID_DATA1); end
    hdr(PID_ACK, 7'd0, 4'd0); idle(3);
  endtask

  task automatic test_in_timeout();
    int b0, d0, f0;
    b0 = beats.size(); d0 = n_done; f0 = n_fail;
    hdr(PID_IN, 7'd0, 4'd1); idle(45);
    tests++; if (n_fail - f0 !== 1 || fail_sel !== 4'b0010 || n_done - d0 !== 0) begin
      fails++; $display("FAIL timeout_fail: got f%0d sel %h d%0d expected 1 2 0", n_fail - f0, fail_sel, n_done - d0); end
    tests++; if (fail_cyc - beats[b0+2].cyc !== 32) begin fails++; $display("FAIL timeout_cycles: got %0d expected 32", fail_cyc - beats[b0+2].cyc); end
    b0 = beats.size();
    hdr(PID_IN, 7'd0, 4'd1); idle(4);
    tests++; if (beats[b0].pid !== PID_DATA0 || beats[b0].data !== 8'hB0) begin fails++; $display("FAIL replay: got %h/%h expected %h/b0", beats[b0].pid, beats[b0].data, PID_DATA0); end
    hdr(PID_ACK, 7'd0, 4'd0); idle(3);
  endtask

  task automatic test_filter_crc();
    int b0, a0, c0, v0;
    b0 = beats.size(); a0 = n_abort; c0 = n_commit;
    hdr(PID_OUT, 7'd0, 4'd3); data_pkt(PID_DATA0, 4, 4, 8'h10, 1'b1); idle(5);
    tests++; if (beats.size() !== b0 || n_abort - a0 !== 1 || n_commit !== c0) begin
      fails++; $display("FAIL crc: got beats%0d a%0d c%0d expected 0 1 0", beats.size() - b0, n_abort - a0, n_commit - c0); end
    a0 = n_abort; v0 = n_rxv;
    hdr(PID_OUT, 7'd5, 4'd0);
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL addr_busy: got %b expected 0", busy); end
    data_pkt(PID_DATA0, 2, 2, 8'h00, 1'b0);
    hdr(PID_IN, 7'd0, 4'd4); idle(4);
    tests++; if (beats.size() !== b0 || n_abort !== a0 || n_rxv !== v0) begin
      fails++; $display("FAIL addr_ignore: got beats%0d a%0d rx%0d expected 0 0 0", beats.size() - b0, n_abort - a0, n_rxv - v0); end
  endtask

  task automatic test_stall_zlp();
    int b0, a0, c0, d0;
    ep_stall = 4'b0010; b0 = beats.size();
    hdr(PID_IN, 7'd0, 4'd1); idle(3);
    tests++; if (beats.size() - b0 !== 1 || beats[b0].pid !== PID_STALL || beats[b0].rd !== 4'h0 || beats[b0].last !== 1'b1) begin
      fails++; $display("FAIL in_stall: got n%0d pid %h rd %h last %b expected 1 %h 0 1", beats.size() - b0, beats[b0].pid, beats[b0].rd, beats[b0].last, PID_STALL); end
    b0 = beats.size(); a0 = n_abort;
    hdr(PID_OUT, 7'd0, 4'd1); data_pkt(PID_DATA0, 2, 2, 8'h00, 1'b0); idle(5);
    tests++; if (beats[b0].pid !== PID_STALL || n_abort - a0 !== 1) begin fails++; $display("FAIL out_stall: got %h a%0d expected %h 1", beats[b0].pid, n_abort - a0, PID_STALL); end
    b0 = beats.size(); c0 = n_commit;
    hdr(PID_SETUP, 7'd0, 4'd1); data_pkt(PID_DATA0, 2, 2, 8'h00, 1'b0); idle(5);
    tests++; if (beats[b0].pid !== PID_ACK || n_commit - c0 !== 1) begin fails++; $display("FAIL setup_stall: got %h c%0d expected %h 1", beats[b0].pid, n_commit - c0, PID_ACK); end
    ep_stall = 4'b0000; b0 = beats.size();
    hdr(PID_IN, 7'd0, 4'd1); idle(4);
    tests++; if (beats[b0].pid !== PID_DATA0) begin fails++; $display("FAIL setup_clr_tx: got %h expected %h", beats[b0].pid, PID_DATA0); end
    hdr(PID_ACK, 7'd0, 4'd0); idle(3);
    b0 = beats.size();
    hdr(PID_IN, 7'd0, 4'd2); idle(3);
    tests++; if (beats[b0].pid !== PID_NAK || beats[b0].len !== 16'd0) begin fails++; $display("FAIL in_nak: got %h expected %h", beats[b0].pid, PID_NAK); end
    ep_tx_req = 4'b0001; ep_tx_len[0 +: LEN_W] = 16'd0; b0 = beats.size(); d0 = n_done;
    hdr(PID_IN, 7'd0, 4'd0); idle(3);
    tests++; if (beats.size() - b0 !== 1 || beats[b0].pid !== PID_DATA0 || beats[b0].len !== 16'd0 || beats[b0].last !== 1'b1 || beats[b0].rd !== 4'h0) begin
      fails++; $display("FAIL zlp: got n%0d pid %h len %0d last %b rd %h expected 1 %h 0 1 0", beats.size() - b0, beats[b0].pid, beats[b0].len, beats[b0].last, beats[b0].rd, PID_DATA0); end
    hdr(PID_ACK, 7'd0, 4'd0); idle(3);
    tests++; if (n_done - d0 !== 1 || done_sel !== 4'b0001) begin fails++; $display("FAIL zlp_done: got %0d sel %h expected 1 1", n_done - d0, done_sel); end
  endtask

  initial begin
    rst_n = 1'b0; dev_addr = 7'd0; ep_stall = '0; host_pkt_valid = 1'b0; host_pid = '0;
    host_addr = '0; host_ep = '0; host_data = '0; host_data_valid = 1'b0; host_data_len = '0;
    host_crc_err = 1'b0; ep_rx_ready = 4'b1111; ep_tx_req = '0; ep_tx_len = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    test_reset();
    test_setup_rx();
    test_dup_out();
    test_len_bounds();
    test_in_ack();
    test_in_timeout();
    test_filter_crc();
    test_stall_zlp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/usb_pkt_router.md
Name: usb_pkt_router

Overview:
- Parametrised successor to the single-EP0/EP1 packet interface.
- Sits between the host-side token/data byte interface (TB or PHY shim) and NUM_EP endpoint engines.
- Adds address filtering, per-endpoint DATA0/DATA1 toggle tracking, and ACK/NAK/STALL handshake generation.
- Adds cycle-accurate byte-streamed TX with a per-byte read strobe, plus timeout and CRC-error handling.

Parameters:
NUM_EP, 4, number of endpoints (1..16); EP index = host_ep[3:0]
MAX_PKT, 64, max data payload bytes per packet
LEN_W, 16, width of length fields
TIMEOUT, 32, cycles to wait for the DATA packet after OUT/SETUP, or for the ACK after IN data

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
dev_addr  in  7  assigned device address
ep_stall  in  NUM_EP  per-EP halt flag
host_pkt_valid  in  1  packet header present (PID valid)
host_pid  in  4  token/data/handshake PID
host_addr  in  7  token address
host_ep  in  4  token endpoint
host_data  in  8  payload byte
host_data_valid  in  1  payload byte strobe
host_data_len  in  LEN_W  payload length of current DATA packet
host_crc_err  in  1  sampled at the last byte or at header (ZLP)
ep_rx_sel  out  NUM_EP  one-hot target EP, held from token to commit/abort
ep_rx_pid  out  4  token PID (SETUP/OUT)
ep_rx_data  out  8  forwarded byte
ep_rx_data_valid  out  1  byte strobe
ep_rx_ready  in  NUM_EP  EP can accept a packet
ep_rx_commit  out  1  pulse: packet good, toggle matched
ep_rx_abort  out  1  pulse: discard buffered bytes
ep_tx_req  in  NUM_EP  EP has an IN packet queued
ep_tx_len  in  NUM_EP*LEN_W  per-EP IN length
ep_tx_data  in  NUM_EP*8  per-EP current byte (FWFT)
ep_tx_rd  out  NUM_EP  one-hot byte pop
ep_tx_done  out  NUM_EP  pulse: host ACKed
ep_tx_fail  out  NUM_EP  pulse: ACK timeout; EP must replay
host_tx_valid  out  1  byte/handshake strobe
host_tx_pid  out  4  outgoing PID
host_tx_data  out  8  outgoing byte
host_tx_len  out  LEN_W  outgoing length (0 for handshake/ZLP)
host_tx_last  out  1  final beat of the outgoing packet
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all toggles 0 (rx expects DATA0, tx sends DATA0), timers 0.
- Token accept (IDLE): host_pkt_valid && PID in {SETUP, OUT, IN} && host_addr==dev_addr && host_ep<NUM_EP. Otherwise ignore and stay in IDLE.
- States: IDLE, WAIT_DATA, RX_DATA, RX_RESP, TX_DATA, WAIT_ACK.
- SETUP/OUT -> WAIT_DATA; ep_rx_sel/ep_rx_pid are registered at the accept edge.
  - SETUP forces the rx and tx toggles of that EP to 0 and ignores ep_stall.
- WAIT_DATA:
  - DATA0/1 header -> RX_DATA; the received PID is latched.
  - host_data_len==0 -> RX_RESP directly.
  - Any other header, or TIMEOUT cycles elapsed -> ep_rx_abort, then IDLE.
- RX_DATA:
  - Each host_data_valid drives ep_rx_data_valid/ep_rx_data the next cycle; a count increments.
  - count reaching host_data_len -> RX_RESP.
  - host_data_len>MAX_PKT -> abort with no handshake.
- RX_RESP (1 cycle), priority order:
  1. crc_err -> ep_rx_abort, no handshake.
  2. ep_stall && !SETUP -> STALL + abort.
  3. !ep_rx_ready -> NAK + abort.
  4. Toggle mismatch -> ACK + abort, toggle unchanged (duplicate).
  5. Otherwise -> ACK + ep_rx_commit, rx toggle flips.
  - A handshake is a single beat: host_tx_valid=1, len=0, last=1. Then IDLE.
- IN token:
  - ep_stall -> STALL.
  - !ep_tx_req -> NAK.
  - Otherwise -> TX_DATA with PID = DATA0/1 from the tx toggle and len = ep_tx_len of that EP.
- TX_DATA:
  - One byte per cycle; ep_tx_rd pulses in the same cycle host_tx_valid presents the byte.
  - host_tx_last on byte len-1.
  - len==0 -> single ZLP beat: valid, len 0, last=1, no ep_tx_rd.
  - Then WAIT_ACK.
- WAIT_ACK:
  - ACK header -> tx toggle flips, ep_tx_done pulse, IDLE.
  - TIMEOUT or any other header -> ep_tx_fail pulse, toggle unchanged, IDLE.
- Tokens arriving while not IDLE are ignored. The router never blocks the host side.
- Asynchronous reset mid-packet returns to IDLE immediately with no pulses emitted.
- Timers saturate; the counter is LEN_W bits wide.

Decomposition:
- usb_defs_pkg: PID_* constants (OUT, IN, SETUP, DATA0, DATA1, ACK, NAK, STALL), the router state_t enum, and an is_token()/is_data() function pair.
- One sub-module, usb_toggle_bank: NUM_EP×2 toggle bits with set/flip/clear ports.

Test Plan:
- SETUP addr=0 ep0, DATA0 of 8 bytes, ready=1 -> 8 ep_rx_data_valid beats, ACK, commit, rx toggle=1.
- OUT ep2 DATA0 sent twice (host lost the ACK) -> first commit; second ACK + abort, toggle still 1.
- IN ep1 with tx_req and len=3 -> DATA0 of 3 beats, ep_tx_rd ×3, last on beat 3; ACK -> done, next IN sends DATA1.
- IN ep1 with no ACK for TIMEOUT=32 cycles -> ep_tx_fail; replay IN -> DATA0 again.
- OUT ep3 with crc_err=1 -> no host_tx_valid, abort. OUT to addr 5 with dev_addr=0 -> ignored, busy stays 0.
- ep_stall[1]=1: IN ep1 -> STALL. SETUP ep1 -> ACK, toggles cleared. IN ep0 with len 0 -> ZLP beat with len 0, last=1.
